mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter that shares a single external memory port between instruction fetch and the load/store path of the core. It grants one requester at a time, drives a request/acknowledge transaction on the memory port, and returns read data or a completion to the winner. A watchdog ends transactions that are never acknowledged. The core stalls fetch or retire on the missing `gnt` and `rvalid` pulses.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, maximum cycles in a transfer before bus-error termination (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch accepted this cycle (combinational)
- `if_rvalid`  out  1  fetch complete, one-cycle pulse
- `if_rdata`  out  DW  fetch data, valid with `if_rvalid`
- `if_err`  out  1  fetch timed out, valid with `if_rvalid`
- `ls_req`  in  1  load/store request; held with payload until `ls_gnt`
- `ls_we`  in  1  1 = store
- `ls_be`  in  DW/8  byte enables
- `ls_addr`  in  AW  data address
- `ls_wdata`  in  DW  store data
- `ls_gnt`, `ls_rvalid`, `ls_rdata`, `ls_err`  out  1/1/DW/1  as the fetch equivalents
- `mem_req`  out  1  memory request, registered
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/DW/8/AW/DW  registered payload
- `mem_ack`  in  1  memory completion
- `mem_rdata`  in  DW  read data, valid with `mem_ack`
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, IF_XFER, LS_XFER.
- **IDLE, no request:** stay in IDLE. All `gnt` outputs are 0.
- **IDLE, request present:**
  - Select a winner and assert its `gnt` combinationally.
  - Capture the payload into the `mem_*` registers at the clock edge.
  - Set `mem_req`=1 and move to the matching XFER state.
  - Fetch payload is forced to `mem_we`=0, `mem_be`=all ones, `mem_wdata`=0.
- **Arbitration:** fixed priority, LSU over IFU (see Configuration for the alternative).
- **XFER:**
  - `mem_req` and the payload are held stable. The `gnt` outputs are 0.
  - A watchdog counter increments every XFER cycle.
- **`mem_ack` sampled high in XFER:**
  - Deassert `mem_req`.
  - Register the winner's `rvalid`=1, `err`=0, and `rdata`=`mem_rdata` (0 on a store).
  - Return to IDLE.
- **Counter reaches `TIMEOUT` without ack:**
  - Deassert `mem_req` and return to IDLE.
  - Pulse the winner's `rvalid` with `err`=1 and `rdata`=0.
- **`mem_ack` and timeout on the same edge:** ack wins, `err`=0.
- **`mem_ack` while IDLE:** ignored, no pulse.
- **Requester behaviour:** dropping `req` before `gnt` is legal and withdraws the request. `req` is a don't-care after `gnt`.
- **Reset values:**
  - FSM = IDLE, watchdog counter = 0.
  - All `mem_*` outputs = 0.
  - `rvalid`, `err`, `rdata` = 0; `busy` = 0.
- **Reset mid-transfer:** immediate abort. `mem_req` goes low asynchronously and no `rvalid` is issued for the dropped transaction.

## Timing
- **Cycle 0:** `gnt` high, IDLE.
- **Cycles 1..N:** `mem_req` high; `mem_ack` is sampled high at the end of cycle N.
- **Cycle N+1:** `rvalid` high, `mem_req` low, state IDLE. A new grant can be issued in this same cycle.
- Minimum request-to-`rvalid` latency is 2 cycles (ack in cycle 1).
- Peak throughput is one transaction per 2 cycles.
- **Timeout:** `rvalid`/`err` appear in cycle `TIMEOUT`+1 after the grant.
- `rvalid` and `err` are exactly one cycle wide. `rdata` holds until the next completion.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration using a one-bit last-winner register, which resets to "LSU".
  - On simultaneous requests, the requester that did not win last is granted, so IFU wins the first contention after reset.
  - The register updates only on a grant.
- `MEM_ARB_RR_EN` undefined: fixed LSU-over-IFU priority, and the last-winner register is not built.

## Test plan
- **Lone fetch:** `if_req`, `if_addr`=0x100, ack in 3rd XFER cycle with `mem_rdata`=0xDEADBEEF.
  - Required: `if_gnt` in cycle 0; `mem_req` cycles 1-3 with `mem_addr`=0x100, `mem_be`=0xF, `mem_we`=0.
  - Required: `if_rvalid` cycle 4 with `if_rdata`=0xDEADBEEF, `if_err`=0.
- **Store:** `ls_we`=1, `ls_be`=0x3, `ls_addr`=0x2000, `ls_wdata`=0x1234, ack in cycle 1.
  - Required: `mem_we`=1 with matching payload; `ls_rvalid` cycle 2 with `ls_rdata`=0.
- **Contention:** `if_req`+`ls_req` held continuously, 1-cycle acks.
  - Without the macro: LSU wins every grant until `ls_req` drops.
  - With `MEM_ARB_RR_EN`: grant order IF, LS, IF, LS.
- **Timeout:** `TIMEOUT`=4, no ack.
  - Required: `mem_req` cycles 1-4; `ls_rvalid`+`ls_err` in cycle 5 with `ls_rdata`=0.
  - Required: ack and timeout on the same edge give `err`=0.
- **Reset mid-transfer:** `rst` low in cycle 2 of an XFER.
  - Required: `mem_req`=0 and `busy`=0 immediately; no `rvalid` after release.
  - Required: the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and external memory-port signal bundle for mem_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    logic            if_err;

    logic            ls_req;
    logic            ls_we;
    logic [DW/8-1:0] ls_be;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [DW-1:0]   ls_rdata;
    logic            ls_err;

    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter for one memory port with a no-ack watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output logic          busy
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_XFER, LS_XFER} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          if_win, ls_win;
    logic          timeout, done;

`ifdef MEM_ARB_RR_EN
    // Remembers whether LSU won the last grant; favours the other side on contention.
    logic last_ls;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 last_ls <= 1'b1;
        else if (ls_win | if_win) last_ls <= ls_win;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if_win    = 1'b0;
        ls_win    = 1'b0;
        timeout   = (cnt == CNT_LAST);
        done      = 1'b0;
        case (state)
            IDLE: begin
`ifdef MEM_ARB_RR_EN
                ls_win = bus.ls_req & (~bus.if_req | ~last_ls);
                if_win = bus.if_req & (~bus.ls_req | last_ls);
`else
                ls_win = bus.ls_req;
                if_win = bus.if_req & ~bus.ls_req;
`endif
                if (ls_win)      state_nxt = LS_XFER;
                else if (if_win) state_nxt = IF_XFER;
            end
            IF_XFER, LS_XFER: begin
                done = bus.mem_ack | timeout;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.if_gnt = if_win;
    assign bus.ls_gnt = ls_win;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rvalid <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.ls_rdata  <= '0;
        end else begin
            bus.if_rvalid <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.ls_rvalid <= 1'b0;
            bus.ls_err    <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (ls_win) begin
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= bus.ls_we;
                    bus.mem_be    <= bus.ls_be;
                    bus.mem_addr  <= bus.ls_addr;
                    bus.mem_wdata <= bus.ls_wdata;
                end else if (if_win) begin
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= 1'b0;
                    bus.mem_be    <= '1;
                    bus.mem_addr  <= bus.if_addr;
                    bus.mem_wdata <= '0;
                end
            end else if (done) begin
                // Ack takes precedence over a simultaneous watchdog expiry.
                cnt         <= '0;
                bus.mem_req <= 1'b0;
                if (state == IF_XFER) begin
                    bus.if_rvalid <= 1'b1;
                    bus.if_err    <= ~bus.mem_ack;
                    bus.if_rdata  <= bus.mem_ack ? bus.mem_rdata : '0;
                end else begin
                    bus.ls_rvalid <= 1'b1;
                    bus.ls_err    <= ~bus.mem_ack;
                    bus.ls_rdata  <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4); honours MEM_ARB_RR_EN for contention order.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.master),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nextc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_ls;
        logic prev_ls;

        bus.if_req = 0; bus.if_addr = '0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;

        nextc(); nextc();
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_if_rvalid", bus.if_rvalid, 0);
        check("rst_ls_rvalid", bus.ls_rvalid, 0);
        check("rst_rdata", bus.if_rdata | bus.ls_rdata, 0);
        check("rst_err", {bus.if_err, bus.ls_err}, 0);
        check("rst_busy", busy, 0);
        rst = 1;

        // Idle: no grants; an ack while idle must be ignored
        nextc(); bus.mem_ack = 1; #1;
        check("idle_gnt", {bus.if_gnt, bus.ls_gnt}, 0);
        nextc(); bus.mem_ack = 0; #1;
        check("idle_ack_no_pulse", {bus.if_rvalid, bus.ls_rvalid}, 0);

        // Lone fetch, ack in third XFER cycle
        nextc(); bus.if_req = 1; bus.if_addr = 32'h100; #1;
        check("fetch_gnt", bus.if_gnt, 1);
        check("fetch_gnt_mem_req", bus.mem_req, 0);
        for (int c = 1; c <= 3; c++) begin
            nextc(); bus.if_req = 0;
            if (c == 3) begin bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF; end
            #1;
            check("fetch_mem_req", bus.mem_req, 1);
            check("fetch_gnt_low", bus.if_gnt, 0);
        end
        check("fetch_addr", bus.mem_addr, 32'h100);
        check("fetch_be", bus.mem_be, 4'hF);
        check("fetch_we", bus.mem_we, 0);
        check("fetch_busy", busy, 1);
        nextc(); bus.mem_ack = 0; #1;
        check("fetch_rvalid", bus.if_rvalid, 1);
        check("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);
        check("fetch_err", bus.if_err, 0);
        check("fetch_done_req", bus.mem_req, 0);
        check("fetch_done_busy", busy, 0);
        nextc(); #1;
        check("fetch_rvalid_pulse", bus.if_rvalid, 0);
        check("fetch_rdata_hold", bus.if_rdata, 32'hDEADBEEF);

        // Store, ack in cycle 1; read data must be forced to zero
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_be = 4'h3; bus.ls_addr = 32'h2000; bus.ls_wdata = 32'h1234; #1;
        check("store_gnt", {bus.if_gnt, bus.ls_gnt}, 2'b01);
        nextc(); bus.ls_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'hFFFFFFFF; #1;
        check("store_req", bus.mem_req, 1);
        check("store_we", bus.mem_we, 1);
        check("store_be", bus.mem_be, 4'h3);
        check("store_addr", bus.mem_addr, 32'h2000);
        check("store_wdata", bus.mem_wdata, 32'h1234);
        nextc(); bus.mem_ack = 0; #1;
        check("store_rvalid", bus.ls_rvalid, 1);
        check("store_rdata", bus.ls_rdata, 0);
        check("store_err", bus.ls_err, 0);
        check("store_no_if_rvalid", bus.if_rvalid, 0);

        // Load giving nonzero ls_rdata
        nextc(); bus.ls_req = 1; bus.ls_we = 0; bus.ls_be = 4'hF; bus.ls_addr = 32'h3000; #1;
        check("load_gnt", bus.ls_gnt, 1);
        nextc(); bus.ls_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D; #1;
        nextc(); bus.mem_ack = 0; #1;
        check("load_rdata", bus.ls_rdata, 32'hCAFEF00D);

        // Timeout: no ack
        nextc(); bus.ls_req = 1; #1;
        check("to_gnt", bus.ls_gnt, 1);
        for (int c = 1; c <= 4; c++) begin
            nextc(); bus.ls_req = 0; #1;
            check("to_mem_req", bus.mem_req, 1);
            check("to_no_rvalid", bus.ls_rvalid, 0);
        end
        nextc(); #1;
        check("to_rvalid", bus.ls_rvalid, 1);
        check("to_err", bus.ls_err, 1);
        check("to_rdata", bus.ls_rdata, 0);
        check("to_mem_req_low", bus.mem_req, 0);
        check("to_busy", busy, 0);
        nextc(); #1;
        check("to_pulse", {bus.ls_rvalid, bus.ls_err}, 0);

        // Ack on the same edge as the timeout
        bus.ls_req = 1; #1;
        for (int c = 1; c <= 4; c++) begin
            nextc(); bus.ls_req = 0;
            if (c == 4) begin bus.mem_ack = 1; bus.mem_rdata = 32'h55AA; end
            #1;
        end
        nextc(); bus.mem_ack = 0; #1;
        check("ackto_rvalid", bus.ls_rvalid, 1);
        check("ackto_err", bus.ls_err, 0);
        check("ackto_rdata", bus.ls_rdata, 32'h55AA);

        // Contention from a fresh reset
        nextc(); rst = 0; #1;
        nextc(); rst = 1;
        nextc();
        bus.if_req = 1; bus.if_addr = 32'h500;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_be = 4'hF; bus.ls_addr = 32'h600;
        prev_ls = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_ack = 0; #1;
            exp_ls = 1'b1;
`ifdef MEM_ARB_RR_EN
            exp_ls = (k % 2 == 1);
`endif
            check("cont_gnt", {bus.if_gnt, bus.ls_gnt}, exp_ls ? 2'b01 : 2'b10);
            if (k > 0) check("cont_rvalid", {bus.if_rvalid, bus.ls_rvalid}, prev_ls ? 2'b01 : 2'b10);
            nextc(); bus.mem_ack = 1; bus.mem_rdata = 32'h1000 + k; #1;
            check("cont_addr", bus.mem_addr, exp_ls ? 32'h600 : 32'h500);
            prev_ls = exp_ls;
            nextc();
        end
        bus.ls_req = 0; bus.mem_ack = 0; #1;
        check("cont_last_rvalid", {bus.if_rvalid, bus.ls_rvalid}, prev_ls ? 2'b01 : 2'b10);
        check("cont_if_after_drop", {bus.if_gnt, bus.ls_gnt}, 2'b10);
        nextc(); bus.if_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h77; #1;
        check("cont_if_addr", bus.mem_addr, 32'h500);
        nextc(); bus.mem_ack = 0; #1;
        check("cont_if_rvalid", bus.if_rvalid, 1);
        check("cont_if_rdata", bus.if_rdata, 32'h77);

        // Reset in cycle 2 of a transfer
        nextc(); bus.if_req = 1; bus.if_addr = 32'h900; #1;
        check("rmt_gnt", bus.if_gnt, 1);
        nextc(); bus.if_req = 0; #1;
        check("rmt_req", bus.mem_req, 1);
        nextc(); rst = 0; #1;
        check("rmt_req_low", bus.mem_req, 0);
        check("rmt_busy_low", busy, 0);
        nextc();
        nextc(); rst = 1; bus.mem_ack = 1; #1;
        for (int c = 0; c < 3; c++) begin
            nextc(); bus.mem_ack = 0; #1;
            check("rmt_no_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 0);
            check("rmt_idle", busy, 0);
        end
        bus.ls_req = 1; bus.ls_addr = 32'h40; bus.ls_we = 0; #1;
        check("rmt_next_gnt", bus.ls_gnt, 1);
        nextc(); bus.ls_req = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D; #1;
        check("rmt_next_addr", bus.mem_addr, 32'h40);
        nextc(); bus.mem_ack = 0; #1;
        check("rmt_next_rvalid", bus.ls_rvalid, 1);
        check("rmt_next_rdata", bus.ls_rdata, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
